// File: rtl/ysyx_22050019_irefill_slave.sv
// Instruction-refill read slave: single AR channel, INCR bursts of 1 or 2 beats
// from a preloadable word memory, with a fixed AR-to-first-beat latency.
module ysyx_22050019_irefill_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic                  ar_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    input  logic                  wr_en_i,
    input  logic [9:0]            wr_idx_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);
    localparam int                    IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WORDS_A   = ADDR_WIDTH'(MEM_WORDS);
    localparam logic [3:0]            WAIT_INIT = 4'(RD_LATENCY > 1 ? RD_LATENCY - 2 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    len_q;
    logic [3:0]              cnt;
    logic                    in_range;
    logic                    ar_hs;
    logic                    load;

    assign offset   = addr_q - BASE_ADDR;
    assign word_idx = offset >> 3;
    assign rd_idx   = word_idx[IDX_W-1:0];
    assign in_range = (addr_q >= BASE_ADDR) && (word_idx < WORDS_A);
    assign rd_word  = mem[rd_idx];
    assign ar_hs    = ar_valid_i && ar_ready_o;
    // Load the first beat once in S_DATA, and the next beat on a non-last handshake.
    assign load     = (state == S_DATA) && (!r_valid_o || (r_ready_i && !r_last_o));

    // Preload port has no reset so memory survives a burst abort.
    always_ff @(posedge clk) begin
        if (wr_en_i && ({22'b0, wr_idx_i} < 32'(MEM_WORDS)))
            mem[IDX_W'(wr_idx_i)] <= wr_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b0;
            r_data_o   <= '0;
            r_resp_o   <= 2'b00;
            r_last_o   <= 1'b0;
            addr_q     <= '0;
            len_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ar_ready_o <= 1'b1;
                    if (ar_hs) begin
                        addr_q     <= ar_addr_i & ~ADDR_WIDTH'(7);
                        len_q      <= ar_len_i;
                        cnt        <= WAIT_INIT;
                        ar_ready_o <= 1'b0;
                        state      <= (RD_LATENCY > 1) ? S_WAIT : S_DATA;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_DATA;
                    else             cnt   <= cnt - 4'd1;
                end
                S_DATA: begin
                    if (load) begin
                        r_valid_o <= 1'b1;
                        r_data_o  <= in_range ? rd_word : '0;
                        r_resp_o  <= in_range ? 2'b00 : 2'b11;
                        // Index of the beat being loaded equals r_valid_o (0 first, 1 second).
                        r_last_o  <= (r_valid_o == len_q);
                        addr_q    <= addr_q + ADDR_WIDTH'(8);
                    end else if (r_valid_o && r_ready_i) begin
                        r_valid_o  <= 1'b0;
                        r_data_o   <= '0;
                        r_resp_o   <= 2'b00;
                        r_last_o   <= 1'b0;
                        ar_ready_o <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050019_irefill_slave.sv
// Randomized bench for the refill slave: a reference memory and address-decode
// model predict every beat; a second instance exercises the single-cycle latency build.
module tb_ysyx_22050019_irefill_slave;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] WORDS = 32'd1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ar_valid = 0, ar_ready, ar_len = 0, r_valid, r_ready = 0, r_last, wr_en = 0;
    logic [31:0] ar_addr = 0;
    logic [63:0] r_data, wr_data = 0;
    logic [1:0]  r_resp;
    logic [9:0]  wr_idx = 0;

    logic        b_ar_valid = 0, b_ar_ready, b_ar_len = 0, b_r_valid, b_r_ready = 0, b_r_last, b_wr_en = 0;
    logic [31:0] b_ar_addr = 0;
    logic [63:0] b_r_data, b_wr_data = 0;
    logic [1:0]  b_r_resp;
    logic [9:0]  b_wr_idx = 0;

    ysyx_22050019_irefill_slave #(.RD_LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len), .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data));

    ysyx_22050019_irefill_slave #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .ar_valid_i(b_ar_valid), .ar_ready_o(b_ar_ready), .ar_addr_i(b_ar_addr),
        .ar_len_i(b_ar_len), .r_valid_o(b_r_valid), .r_ready_i(b_r_ready), .r_data_o(b_r_data),
        .r_resp_o(b_r_resp), .r_last_o(b_r_last), .wr_en_i(b_wr_en), .wr_idx_i(b_wr_idx), .wr_data_i(b_wr_data));

    int          checks = 0;
    int          errors = 0;
    logic [63:0] ref_mem [1024];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < WORDS);
    endfunction

    function automatic logic [63:0] exp_data(input logic [31:0] a);
        if (in_rng(a)) return ref_mem[int'((a - BASE) >> 3)];
        return 64'd0;
    endfunction

    task automatic wr(input int idx, input logic [63:0] d);
        wr_en = 1; wr_idx = 10'(idx); wr_data = d;
        tick();
        wr_en = 0;
        ref_mem[idx] = d;
    endtask

    // One burst on the main instance with fixed stall counts per beat; optional
    // same-edge preload of beat 1's word while beat 0 is handshaken.
    task automatic run_burst(input logic [31:0] addr, input logic len, input int st0, input int st1,
                             input bit collide);
        logic [31:0] a0;
        logic [63:0] ed [2];
        logic [1:0]  er [2];
        logic [63:0] newd;
        int          n, stalls;
        a0 = addr & ~32'h7;
        for (int b = 0; b < 2; b++) begin
            ed[b] = exp_data(a0 + 32'(8 * b));
            er[b] = in_rng(a0 + 32'(8 * b)) ? 2'b00 : 2'b11;
        end
        n = 0;
        while (!ar_ready && n < 10) begin tick(); n++; end
        chk("ar_ready_idle", ar_ready, 1);
        ar_valid = 1; ar_addr = addr; ar_len = len;
        tick();
        ar_valid = 0; ar_addr = $urandom; ar_len = 1'($urandom);
        chk("ar_ready_busy", ar_ready, 0);
        n = 0;
        while (!r_valid && n < 20) begin tick(); n++; end
        chk("latency", n, LAT);
        for (int b = 0; b <= int'(len); b++) begin
            stalls = (b == 0) ? st0 : st1;
            for (int s = 0; s <= stalls; s++) begin
                chk("r_valid", r_valid, 1);
                chk("r_data", r_data, ed[b]);
                chk("r_resp", r_resp, er[b]);
                chk("r_last", r_last, (b == int'(len)) ? 1 : 0);
                if (s < stalls) begin r_ready = 0; tick(); end
            end
            r_ready = 1;
            newd = {$urandom, $urandom};
            if (collide && b == 0 && len && in_rng(a0 + 32'd8)) begin
                wr_en = 1; wr_idx = 10'((a0 + 32'd8 - BASE) >> 3); wr_data = newd;
            end
            tick();
            if (wr_en) ref_mem[int'(wr_idx)] = wr_data;
            wr_en = 0; r_ready = 0;
        end
        chk("end_valid", r_valid, 0);
        chk("end_ar_ready", ar_ready, 1);
        chk("end_data", r_data, 0);
        chk("end_last", r_last, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        int          kind;
        // Reset state
        tick(); tick();
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_r_resp", r_resp, 0);
        chk("rst_r_last", r_last, 0);
        rst = 1;
        tick();
        chk("post_rst_ar_ready", ar_ready, 1);

        // Preload both instances with identical contents.
        for (int i = 0; i < 1024; i++) begin
            wr_data = {$urandom, $urandom};
            wr_en = 1; wr_idx = 10'(i);
            b_wr_en = 1; b_wr_idx = 10'(i); b_wr_data = wr_data;
            ref_mem[i] = wr_data;
            tick();
        end
        wr_en = 0; b_wr_en = 0;

        // Latency-1 instance: request held high, single-beat bursts back to back.
        chk("l1_ar_ready", b_ar_ready, 1);
        b_r_ready = 1; b_ar_valid = 1; b_ar_addr = 32'h8000_0008; b_ar_len = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("l1_r_valid", b_r_valid, (k % 3 == 2) ? 1 : 0);
            chk("l1_ar_ready_k", b_ar_ready, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 2) begin
                chk("l1_r_data", b_r_data, ref_mem[1]);
                chk("l1_r_last", b_r_last, 1);
                chk("l1_r_resp", b_r_resp, 0);
            end
        end
        b_ar_valid = 0; b_r_ready = 0;

        // Directed bursts
        wr(0, 64'h1111); wr(1, 64'h2222);
        run_burst(32'h8000_0004, 1'b1, 0, 0, 0);
        run_burst(32'h8000_0004, 1'b1, 3, 0, 0);
        run_burst(32'h8000_1FF8, 1'b1, 0, 1, 0);
        run_burst(32'h7FFF_FFF8, 1'b0, 0, 0, 0);
        run_burst(32'h8000_0100, 1'b1, 1, 0, 1);
        run_burst(32'h8000_0100, 1'b1, 0, 0, 0);

        // Reset during beat 0
        ar_valid = 1; ar_addr = 32'h8000_0010; ar_len = 1;
        tick();
        ar_valid = 0;
        for (int n = 0; n < 20 && !r_valid; n++) tick();
        chk("mid_valid_pre", r_valid, 1);
        #2 rst = 0;
        #1;
        chk("mid_rst_valid", r_valid, 0);
        chk("mid_rst_data", r_data, 0);
        chk("mid_rst_ar_ready", ar_ready, 0);
        @(posedge clk); #1 rst = 1;
        tick();
        chk("mid_rel_ar_ready", ar_ready, 1);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_stale", r_valid, 0);
            tick();
        end
        run_burst(32'h8000_0010, 1'b1, 0, 0, 0);

        // Randomized bursts
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, 1023)), {$urandom, $urandom});
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: ra = 32'h8000_1FF8;
                1: ra = 32'h7FFF_FFF8 + 32'($urandom_range(0, 7));
                2: ra = 32'h9000_0000 + 32'($urandom_range(0, 255));
                default: ra = BASE + 32'($urandom_range(0, 1023) * 8) + 32'($urandom_range(0, 7));
            endcase
            run_burst(ra, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      kind >= 3 && $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22050019_irefill_slave.md
YSYX_22050019_IREFILL_SLAVE -- requirements
Module: ysyx_22050019_irefill_slave

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 32, request address width; DATA_WIDTH, 64, beat width; MEM_WORDS, 1024, backing-store depth in 64-bit words; BASE_ADDR, 32'h8000_0000, byte address of word 0; RD_LATENCY, 2, cycles from AR handshake to first r_valid, legal range 1..15.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- ar_valid_i, in, 1, read request valid.
- ar_ready_o, out, 1, request accepted.
- ar_addr_i, in, ADDR_WIDTH, burst start byte address.
- ar_len_i, in, 1, beats minus one: 0 means 1 beat, 1 means 2 beats.
- r_valid_o, out, 1, read beat valid.
- r_ready_i, in, 1, requester accepts beat.
- r_data_o, out, DATA_WIDTH, beat data.
- r_resp_o, out, 2, 2'b00 OKAY, 2'b11 DECERR.
- r_last_o, out, 1, final beat of burst.
- wr_en_i, in, 1, preload write strobe.
- wr_idx_i, in, 10, preload word index.
- wr_data_i, in, DATA_WIDTH, preload data.

Function
REQ-004 The FSM has three states: S_IDLE, S_WAIT and S_DATA. Transitions:
- S_IDLE to S_WAIT on AR handshake when RD_LATENCY > 1.
- S_IDLE to S_DATA on AR handshake when RD_LATENCY == 1.
- S_WAIT to S_DATA when the latency counter expires.
- S_DATA to S_IDLE on handshake of the last beat.
REQ-005 ar_ready_o is 1 only in S_IDLE; it is 0 during S_WAIT and S_DATA.
REQ-006 On AR handshake at edge T, the block registers the beat address (ar_addr_i with bits [2:0] forced to 0) and ar_len_i; r_valid_o rises at edge T+RD_LATENCY.
REQ-007 The burst type is INCR: beat n address = start + 8*n; no wrap.
REQ-008 Per-beat decode: index = (addr - BASE_ADDR) >> 3.
- In range (addr >= BASE_ADDR and index < MEM_WORDS): r_data_o = mem[index], r_resp_o = 2'b00.
- Out of range: r_data_o = 0, r_resp_o = 2'b11.
- A burst may be OKAY on beat 0 and DECERR on beat 1.
REQ-009 r_last_o = 1 exactly when the beat presented is beat ar_len; it is 0 at all other times.
REQ-010 Backpressure: while r_valid_o=1 and r_ready_i=0, r_data_o, r_resp_o and r_last_o hold stable.
REQ-011 On a non-last beat handshake, the next beat is valid in the following cycle (no bubble).
REQ-012 On the last beat handshake, r_valid_o falls and ar_ready_o rises in the following cycle.
REQ-013 r_data_o is registered; it is sampled from mem when the beat is loaded. A preload write to the same word in the same cycle is not seen by that beat (old data returned).
REQ-014 Preload writes are accepted in any state. wr_idx_i >= MEM_WORDS is ignored.
REQ-015 ar_valid_i outside S_IDLE is ignored and is not queued.
REQ-016 When r_valid_o=0, r_data_o, r_resp_o and r_last_o are 0.

Reset
REQ-017 While rst=0: state S_IDLE, ar_ready_o=0, r_valid_o=0, r_data_o=0, r_resp_o=0, r_last_o=0, counters 0.
REQ-018 The first clock edge after rst deasserts sets ar_ready_o=1.
REQ-019 Reset mid-burst aborts the burst immediately with no further beats. Memory contents are not cleared by reset.

Verification
REQ-020 Preload mem[0]=64'h1111, mem[1]=64'h2222; AR addr 32'h8000_0004, len 1, r_ready_i=1:
- beat 0 = 1111 OKAY last=0 at T+2;
- beat 1 = 2222 OKAY last=1 at T+3;
- ar_ready_o=1 at T+4.
REQ-021 Same burst with r_ready_i=0 for 3 cycles on beat 0: r_data_o holds 1111 for those 3 cycles; beat 1 follows the cycle after the handshake.
REQ-022 AR addr 32'h8000_1FF8, len 1 (MEM_WORDS=1024): beat 0 = mem[1023] OKAY; beat 1 = data 0, resp 2'b11, last=1.
REQ-023 AR addr 32'h7FFF_FFF8, len 0: one beat, data 0, resp 2'b11, last=1.
REQ-024 Assert rst=0 during S_DATA beat 0: r_valid_o=0 asynchronously; after release, ar_ready_o=1 and no stale beat appears.
REQ-025 RD_LATENCY=1 build with back-to-back bursts: r_valid_o is 1 the edge after each AR handshake; ar_valid_i held high during S_DATA is not accepted until S_IDLE.
